// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter sharing one RAM port between an
// instruction fetch path and a data path.
//
// Optional build macro: RAM_ARBITER_STARVE_GUARD_EN
//   Defined   -> a 4-bit counter limits how many consecutive data grants are
//                taken while an instruction fetch waits (STARVE_LIMIT).
//   Undefined -> strict data priority, no counter present.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   iREN, iaddr       instruction read request and word address
//   iwait, iload      instruction stall (0 only on completion) and read data
//   dREN, dWEN        data read / write requests (both high = write)
//   daddr, dstore     data address and write data
//   dwait, dload      data stall (0 only on completion) and read data
//   ramREN, ramWEN    RAM strobes, never both high
//   ramaddr, ramstore RAM address and write data
//   ramload           RAM read data
//   ramstate          RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
module ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("ram_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    state_t    state;
    state_t    state_next;
    ramstate_t rs;
    logic      d_req;
    logic      starve_force;

    always_comb begin
        rs    = ramstate_t'(ramstate);
        d_req = dREN | dWEN;
    end

    // Read data is a plain pass-through; requesters qualify it with their wait.
    always_comb begin
        iload = ramload;
        dload = ramload;
    end

`ifdef RAM_ARBITER_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_comb begin
        starve_force = (starve_cnt == LIMIT) && iREN;
    end

    // Counts data grants that overtook a waiting fetch; an instruction
    // grant resets the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (state_next == IGRANT) begin
                starve_cnt <= '0;
            end else if (state_next == DGRANT && iREN && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    always_comb begin
        starve_force = 1'b0;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;

        unique case (state)
            IDLE: begin
                if (d_req && !starve_force) begin
                    state_next = DGRANT;
                end else if (iREN) begin
                    state_next = IGRANT;
                end
            end

            DGRANT: begin
                // Simultaneous read and write is treated as a write.
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (rs == RAM_ACCESS) begin
                    dwait      = 1'b0;
                    state_next = IDLE;
                end else if (rs == RAM_ERROR || !d_req) begin
                    // Error retries via re-arbitration; a dropped request aborts.
                    state_next = IDLE;
                end
            end

            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (rs == RAM_ACCESS) begin
                    iwait      = 1'b0;
                    state_next = IDLE;
                end else if (rs == RAM_ERROR || !iREN) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
